// File: rtl/frame_xmtr.sv
// Serial frame transmitter: sends the MATCH header then the payload byte, MSB first,
// on one wire. A holding register in front of the shift register lets the producer
// queue the next byte while the current frame goes out.
// Optional build macro FRAME_XMTR_PARITY_EN appends an even-parity bit after the payload.
module frame_xmtr #(
  parameter logic [7:0]  MATCH = 8'hA5,
  parameter int unsigned GAP   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       full,
  output logic       busy,
  output logic       overrun,
  output logic       data_out
);

  localparam logic [3:0] GapLen = 4'(GAP);

`ifdef FRAME_XMTR_PARITY_EN
  typedef enum logic [2:0] {StIdle, StHead, StBody, StGap, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHead, StBody, StGap} state_e;
`endif

  state_e     state_q;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic [3:0] bit_cnt_q;
  logic [3:0] gap_cnt_q;
  logic       full_q;
  logic       busy_q;
  logic       overrun_q;
  logic       data_out_q;
`ifdef FRAME_XMTR_PARITY_EN
  logic       parity_q;
`endif

  logic frame_end;
  logic load;
  logic accept;

  // Frame-end detection, hold-to-shift transfer and write acceptance
  always_comb begin
`ifdef FRAME_XMTR_PARITY_EN
    frame_end = (state_q == StPar);
`else
    frame_end = (state_q == StBody) && (bit_cnt_q == 4'd7);
`endif
    load   = full_q && ((state_q == StIdle) ||
                        (frame_end && (GapLen == 4'd0)) ||
                        ((state_q == StGap) && (gap_cnt_q == 4'd1)));
    // A write while full is still taken if the hold register empties on this edge
    accept = writing && (!full_q || load);
  end

  // Transmit FSM with registered serial output and status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_q     <= 8'h00;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      gap_cnt_q  <= 4'd0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      data_out_q <= ~MATCH[7];
`ifdef FRAME_XMTR_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        hold_q    <= data_in;
        full_q    <= 1'b1;
        overrun_q <= 1'b0;
      end else begin
        if (load) full_q <= 1'b0;
        if (writing) overrun_q <= 1'b1;
      end

      if (load) begin
        shift_q    <= hold_q;
`ifdef FRAME_XMTR_PARITY_EN
        parity_q   <= ^hold_q;
`endif
        state_q    <= StHead;
        data_out_q <= MATCH[7];
        bit_cnt_q  <= 4'd0;
        busy_q     <= 1'b1;
      end else if (frame_end) begin
        // Line goes to idle level whether a gap follows or not
        data_out_q <= ~MATCH[7];
        if (GapLen != 4'd0) begin
          state_q   <= StGap;
          gap_cnt_q <= GapLen;
        end else begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          StIdle: ;
          StHead: begin
            if (bit_cnt_q == 4'd7) begin
              state_q    <= StBody;
              data_out_q <= shift_q[7];
              shift_q    <= {shift_q[6:0], 1'b0};
              bit_cnt_q  <= 4'd0;
            end else begin
              data_out_q <= MATCH[3'd6 - bit_cnt_q[2:0]];
              bit_cnt_q  <= bit_cnt_q + 4'd1;
            end
          end
          StBody: begin
            if (bit_cnt_q == 4'd7) begin
`ifdef FRAME_XMTR_PARITY_EN
              state_q    <= StPar;
              data_out_q <= parity_q;
`endif
            end else begin
              data_out_q <= shift_q[7];
              shift_q    <= {shift_q[6:0], 1'b0};
              bit_cnt_q  <= bit_cnt_q + 4'd1;
            end
          end
          StGap: begin
            if (gap_cnt_q == 4'd1) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q - 4'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign full     = full_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign data_out = data_out_q;

endmodule
